xvc_jtag_responder: RTL and testbench

Responder end of the XVC memory-map command interface: decodes WAIT/WRITE/READ commands against a five-register JTAG shift block (LENGTH, TMS, TDI, TDO, CONTROL) and, on a CONTROL start, shifts up to 32 bits out on TCK/TMS/TDI while capturing TDO. It sits between the XVC controller core and the FPGA's BSCAN/JTAG pins, with one outstanding command at a time and pulsed `wdone`/`rvalid` responses.

---
 rtl/xvc_jtag_responder_if.sv | 44 ++++
 rtl/xvc_jtag_responder.sv | 216 +++++++++++++++++++++
 tb/tb_xvc_jtag_responder.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/xvc_jtag_responder_if.sv
// ---------------------------------------------------------------------------
// xvc_jtag_responder_if
//
// Command/response bus between the XVC controller core (master) and the JTAG
// shift responder (slave). One outstanding command at a time.
//
// Signals:
//   addr   [15:0]  master -> slave  byte address of the target register
//   wdata  [31:0]  master -> slave  write data
//   opcode [1:0]   master -> slave  0 WAIT, 1 WRITE, 2 READ, 3 WAIT
//   rdata  [31:0]  slave -> master  read data, zero outside rvalid
//   rvalid         slave -> master  one-cycle read-complete pulse
//   wdone          slave -> master  one-cycle write-complete pulse
//   busy           slave -> master  responder is not accepting commands
// ---------------------------------------------------------------------------
interface xvc_jtag_responder_if;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [1:0]  opcode;
    logic [31:0] rdata;
    logic        rvalid;
    logic        wdone;
    logic        busy;

    modport master (
        output addr,
        output wdata,
        output opcode,
        input  rdata,
        input  rvalid,
        input  wdone,
        input  busy
    );

    modport slave (
        input  addr,
        input  wdata,
        input  opcode,
        output rdata,
        output rvalid,
        output wdone,
        output busy
    );
endinterface

// File: rtl/xvc_jtag_responder.sv
// ---------------------------------------------------------------------------
// xvc_jtag_responder
//
// Decodes WAIT/WRITE/READ commands against a five-register JTAG shift block
// (LENGTH 0x00, TMS 0x04, TDI 0x08, TDO 0x0C read-only, CONTROL 0x10). A write
// of CONTROL with bit0 set launches a shift of min(LENGTH,32) bits, LSB first,
// on tck/tms/tdi while capturing tdo into the TDO register.
//
// Parameters:
//   TCK_DIV  tck half-period in clk cycles (1..255)
//
// Ports:
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of xvc_jtag_responder_if (command/response bus)
//   tck    out  JTAG clock
//   tms    out  JTAG mode select, holds last driven value between shifts
//   tdi    out  JTAG data to target, holds last driven value between shifts
//   tdo    in   JTAG data from target, already synchronous to clk
// ---------------------------------------------------------------------------
module xvc_jtag_responder #(
    parameter int unsigned TCK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    xvc_jtag_responder_if.slave   bus,
    output logic                  tck,
    output logic                  tms,
    output logic                  tdi,
    input  logic                  tdo
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESP  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GUARD = 2'd3
    } state_t;

    localparam logic [1:0] OP_WRITE   = 2'd1;
    localparam logic [1:0] OP_READ    = 2'd2;
    localparam logic [7:0] PHASE_LAST = 8'(TCK_DIV - 1);

    localparam logic [4:0] OFS_LENGTH  = 5'h00;
    localparam logic [4:0] OFS_TMS     = 5'h04;
    localparam logic [4:0] OFS_TDI     = 5'h08;
    localparam logic [4:0] OFS_TDO     = 5'h0C;
    localparam logic [4:0] OFS_CONTROL = 5'h10;

    // Architectural registers
    state_t      state_q;
    logic [31:0] len_q;
    logic [31:0] tms_reg_q;
    logic [31:0] tdi_reg_q;
    logic [31:0] tdo_reg_q;
    logic        ctrl_q;

    // Shift engine
    logic [4:0]  bit_q;
    logic [4:0]  last_bit_q;
    logic [7:0]  phase_q;

    // Registered outputs
    logic [31:0] rdata_q;
    logic        rvalid_q;
    logic        wdone_q;
    logic        busy_q;
    logic        tck_q;
    logic        tms_q;
    logic        tdi_q;

    // Address decode: the upper bits must be zero for any register to match,
    // so every alias outside the 32-byte window falls through as unmapped.
    logic        addr_hi_ok;
    logic        sel_len;
    logic        sel_tms;
    logic        sel_tdi;
    logic        sel_ctrl;
    logic [5:0]  eff_len;
    logic [31:0] rd_val;

    assign addr_hi_ok = (bus.addr[15:5] == 11'd0);
    assign sel_len    = addr_hi_ok && (bus.addr[4:0] == OFS_LENGTH);
    assign sel_tms    = addr_hi_ok && (bus.addr[4:0] == OFS_TMS);
    assign sel_tdi    = addr_hi_ok && (bus.addr[4:0] == OFS_TDI);
    assign sel_ctrl   = addr_hi_ok && (bus.addr[4:0] == OFS_CONTROL);

    // LENGTH keeps the full 32-bit written value; only the shift length is
    // clamped to the 32-bit capacity of the TMS/TDI/TDO registers.
    assign eff_len = (len_q > 32'd32) ? 6'd32 : len_q[5:0];

    always_comb begin
        rd_val = 32'd0;
        if (addr_hi_ok) begin
            case (bus.addr[4:0])
                OFS_LENGTH:  rd_val = len_q;
                OFS_TMS:     rd_val = tms_reg_q;
                OFS_TDI:     rd_val = tdi_reg_q;
                OFS_TDO:     rd_val = tdo_reg_q;
                OFS_CONTROL: rd_val = {31'd0, ctrl_q};
                default:     rd_val = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= 32'd0;
            tms_reg_q  <= 32'd0;
            tdi_reg_q  <= 32'd0;
            tdo_reg_q  <= 32'd0;
            ctrl_q     <= 1'b0;
            bit_q      <= 5'd0;
            last_bit_q <= 5'd0;
            phase_q    <= 8'd0;
            rdata_q    <= 32'd0;
            rvalid_q   <= 1'b0;
            wdone_q    <= 1'b0;
            busy_q     <= 1'b0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b0;
            tdi_q      <= 1'b0;
        end else begin
            // Response strobes are single-cycle by construction.
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            rdata_q  <= 32'd0;

            case (state_q)
                ST_IDLE: begin
                    if (bus.opcode == OP_WRITE) begin
                        wdone_q <= 1'b1;
                        state_q <= ST_RESP;
                        if (sel_len) len_q     <= bus.wdata;
                        if (sel_tms) tms_reg_q <= bus.wdata;
                        if (sel_tdi) tdi_reg_q <= bus.wdata;
                        // A start with zero effective length is a no-op: the
                        // CONTROL bit stays clear and TDO keeps its contents.
                        if (sel_ctrl) begin
                            if (bus.wdata[0] && (eff_len != 6'd0)) begin
                                ctrl_q     <= 1'b1;
                                tdo_reg_q  <= 32'd0;
                                last_bit_q <= 5'(eff_len - 6'd1);
                            end else begin
                                ctrl_q <= 1'b0;
                            end
                        end
                    end else if (bus.opcode == OP_READ) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= rd_val;
                        state_q  <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    // ctrl_q can only be set here by the command just taken,
                    // so it doubles as the "launch a shift" flag.
                    busy_q <= 1'b1;
                    if (ctrl_q) begin
                        state_q <= ST_SHIFT;
                        bit_q   <= 5'd0;
                        phase_q <= 8'd0;
                        tck_q   <= 1'b0;
                        tms_q   <= tms_reg_q[0];
                        tdi_q   <= tdi_reg_q[0];
                    end else begin
                        state_q <= ST_GUARD;
                    end
                end

                ST_SHIFT: begin
                    if (phase_q == PHASE_LAST) begin
                        phase_q <= 8'd0;
                        if (!tck_q) begin
                            // End of low phase: raise tck and capture tdo.
                            tck_q            <= 1'b1;
                            tdo_reg_q[bit_q] <= tdo;
                        end else if (bit_q == last_bit_q) begin
                            tck_q   <= 1'b0;
                            ctrl_q  <= 1'b0;
                            state_q <= ST_GUARD;
                        end else begin
                            // End of high phase: present the next bit.
                            bit_q <= bit_q + 5'd1;
                            tck_q <= 1'b0;
                            tms_q <= tms_reg_q[bit_q + 5'd1];
                            tdi_q <= tdi_reg_q[bit_q + 5'd1];
                        end
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end

                ST_GUARD: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.wdone  = wdone_q;
    assign bus.busy   = busy_q;
    assign tck        = tck_q;
    assign tms        = tms_q;
    assign tdi        = tdi_q;

endmodule

// File: tb/tb_xvc_jtag_responder.sv
// ---------------------------------------------------------------------------
// tb_xvc_jtag_responder
//
// Directed and randomized command sequences against xvc_jtag_responder with
// TCK_DIV=2. Expected register contents, read data and shift results come
// from a register-level model of the block kept in this file.
// ---------------------------------------------------------------------------
module tb_xvc_jtag_responder;

    localparam int DIV = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tck;
    logic tms;
    logic tdi;
    logic tdo;
    int   tdo_mode = 0;   // 0: loop tdi, 1: constant 1, 2: inverted tdi

    always #5 clk = ~clk;

    xvc_jtag_responder_if bus_if ();

    xvc_jtag_responder #(.TCK_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave),
        .tck   (tck),
        .tms   (tms),
        .tdi   (tdi),
        .tdo   (tdo)
    );

    assign tdo = (tdo_mode == 0) ? tdi : ((tdo_mode == 1) ? 1'b1 : ~tdi);

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    // tck edge log: total rising edges and the tms value seen at each one
    int   rise_cnt = 0;
    logic tms_log[$];
    always @(posedge tck) begin
        rise_cnt = rise_cnt + 1;
        tms_log.push_back(tms);
    end

    // Response-strobe rule: never both, never two cycles in a row
    int   pulse_viol = 0;
    logic prev_pulse = 1'b0;
    always @(negedge clk) begin
        if (bus_if.wdone && bus_if.rvalid) pulse_viol = pulse_viol + 1;
        if (prev_pulse && (bus_if.wdone || bus_if.rvalid)) pulse_viol = pulse_viol + 1;
        prev_pulse = bus_if.wdone || bus_if.rvalid;
    end

    // Register-level model
    logic [31:0] m_len, m_tms, m_tdi, m_tdo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int eff_n();
        return (m_len > 32) ? 32 : int'(m_len);
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a);
        case (a)
            16'h0000: return m_len;
            16'h0004: return m_tms;
            16'h0008: return m_tdi;
            16'h000C: return m_tdo;
            default:  return 32'd0;   // CONTROL reads 0 whenever idle
        endcase
    endfunction

    function automatic logic [31:0] low_mask(input int n);
        logic [31:0] one;
        one = 32'd1;
        return (n >= 32) ? 32'hFFFF_FFFF : ((one << n) - 32'd1);
    endfunction

    // Issue one command and check the full response/busy/shift behaviour.
    task automatic cmd(input logic [1:0] op, input logic [15:0] a, input logic [31:0] d);
        logic        is_wr, is_rd, starts;
        int          n, base, cyc;
        logic [31:0] exp_rd, mask, seq, exp_tdo;
        is_wr  = (op == 2'd1);
        is_rd  = (op == 2'd2);
        n      = eff_n();
        starts = is_wr && (a == 16'h0010) && d[0] && (n > 0);
        exp_rd = model_read(a);
        @(negedge clk);
        bus_if.opcode = op;
        bus_if.addr   = a;
        bus_if.wdata  = d;
        base = rise_cnt;
        @(negedge clk);
        chk($sformatf("wdone op%0d a%04h", op, a), {31'd0, bus_if.wdone}, {31'd0, is_wr});
        chk($sformatf("rvalid op%0d a%04h", op, a), {31'd0, bus_if.rvalid}, {31'd0, is_rd});
        chk($sformatf("rdata op%0d a%04h", op, a), bus_if.rdata, is_rd ? exp_rd : 32'd0);
        bus_if.opcode = 2'd0;
        if (is_wr) begin
            case (a)
                16'h0000: m_len = d;
                16'h0004: m_tms = d;
                16'h0008: m_tdi = d;
                default: ;
            endcase
        end
        @(negedge clk);
        if (!is_wr && !is_rd) begin
            chk("wait_busy", {31'd0, bus_if.busy}, 32'd0);
            return;
        end
        chk($sformatf("busy_t2 a%04h", a), {31'd0, bus_if.busy}, 32'd1);
        if (starts) begin
            cyc = 1;
            for (int k = 0; k < 2000 && bus_if.busy; k++) begin
                @(negedge clk);
                if (bus_if.busy) cyc++;
            end
            mask = low_mask(n);
            seq  = 32'd0;
            for (int i = 0; i < n && (base + i) < tms_log.size(); i++) seq[i] = tms_log[base + i];
            chk($sformatf("busy_len n%0d", n), cyc, 2 * DIV * n + 1);
            chk($sformatf("tck_rises n%0d", n), rise_cnt - base, n);
            chk($sformatf("tms_seq n%0d", n), seq, m_tms & mask);
            chk("tms_hold", {31'd0, tms}, {31'd0, m_tms[n-1]});
            chk("tdi_hold", {31'd0, tdi}, {31'd0, m_tdi[n-1]});
            chk("tck_idle", {31'd0, tck}, 32'd0);
            case (tdo_mode)
                0:       exp_tdo = m_tdi & mask;
                1:       exp_tdo = mask;
                default: exp_tdo = ~m_tdi & mask;
            endcase
            m_tdo = exp_tdo;
        end else begin
            @(negedge clk);
            chk($sformatf("busy_t3 a%04h", a), {31'd0, bus_if.busy}, 32'd0);
            chk($sformatf("no_tck a%04h", a), rise_cnt - base, 0);
        end
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [15:0] r_addr;
        logic [31:0] r_data;
        int          rises0;

        bus_if.opcode = 2'd0;
        bus_if.addr   = 16'd0;
        bus_if.wdata  = 32'd0;
        m_len = 0; m_tms = 0; m_tdi = 0; m_tdo = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rdata", bus_if.rdata, 32'd0);
        chk("rst_flags", {25'd0, bus_if.rvalid, bus_if.wdone, bus_if.busy, tck, tms, tdi, 1'b0}, 32'd0);
        rst_n = 1'b1;

        // 8-bit shift, tdo looped back to tdi
        tdo_mode = 0;
        cmd(2'd1, 16'h0000, 32'd8);
        cmd(2'd1, 16'h0004, 32'h0000_00A5);
        cmd(2'd1, 16'h0008, 32'h0000_003C);
        cmd(2'd1, 16'h0010, 32'd1);
        cmd(2'd2, 16'h0010, 32'd0);
        cmd(2'd2, 16'h000C, 32'd0);

        // LENGTH above 32 clamps to 32 bits, LENGTH reads back unchanged
        tdo_mode = 1;
        cmd(2'd1, 16'h0000, 32'd40);
        cmd(2'd1, 16'h0008, 32'hFFFF_FFFF);
        cmd(2'd1, 16'h0010, 32'd1);
        cmd(2'd2, 16'h000C, 32'd0);
        cmd(2'd2, 16'h0000, 32'd0);

        // Zero-length start
        cmd(2'd1, 16'h0000, 32'd0);
        cmd(2'd1, 16'h0010, 32'd1);
        cmd(2'd2, 16'h0010, 32'd0);

        // Initiator holds WRITE LENGTH through the response cycle and one more
        @(negedge clk);
        bus_if.opcode = 2'd1; bus_if.addr = 16'h0000; bus_if.wdata = 32'd5;
        @(negedge clk);
        chk("hold_wdone_t1", {31'd0, bus_if.wdone}, 32'd1);
        @(negedge clk);
        chk("hold_wdone_t2", {31'd0, bus_if.wdone}, 32'd0);
        bus_if.opcode = 2'd0;
        @(negedge clk);
        chk("hold_wdone_t3", {31'd0, bus_if.wdone}, 32'd0);
        chk("hold_busy_t3", {31'd0, bus_if.busy}, 32'd0);
        @(negedge clk);
        chk("hold_wdone_t4", {31'd0, bus_if.wdone}, 32'd0);
        m_len = 32'd5;
        cmd(2'd0, 16'h0004, 32'h1111_1111);
        cmd(2'd1, 16'h0004, 32'h1234_5678);
        cmd(2'd2, 16'h0004, 32'd0);
        cmd(2'd2, 16'h0000, 32'd0);

        // Unmapped and read-only accesses
        cmd(2'd2, 16'h0020, 32'd0);
        cmd(2'd1, 16'h000C, 32'hDEAD_BEEF);
        cmd(2'd2, 16'h000C, 32'd0);
        cmd(2'd1, 16'h0104, 32'hCAFE_F00D);
        cmd(2'd2, 16'h0004, 32'd0);
        cmd(2'd2, 16'h0006, 32'd0);
        cmd(2'd3, 16'h0000, 32'hFFFF_FFFF);

        // Reset asserted during bit 3 of a 16-bit shift
        cmd(2'd1, 16'h0000, 32'd16);
        cmd(2'd1, 16'h0004, $urandom);
        cmd(2'd1, 16'h0008, $urandom);
        @(negedge clk);
        bus_if.opcode = 2'd1; bus_if.addr = 16'h0010; bus_if.wdata = 32'd1;
        rises0 = rise_cnt;
        @(negedge clk);
        bus_if.opcode = 2'd0;
        for (int k = 0; k < 500 && !((rise_cnt - rises0) == 3 && tck == 1'b0); k++) @(negedge clk);
        chk("reach_bit3", rise_cnt - rises0, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rdata", bus_if.rdata, 32'd0);
        chk("arst_flags", {25'd0, bus_if.rvalid, bus_if.wdone, bus_if.busy, tck, tms, tdi, 1'b0}, 32'd0);
        rises0 = rise_cnt;
        repeat (5) @(negedge clk);
        chk("arst_no_tck", rise_cnt - rises0, 0);
        rst_n = 1'b1;
        m_len = 0; m_tms = 0; m_tdi = 0; m_tdo = 0;
        cmd(2'd2, 16'h0010, 32'd0);
        cmd(2'd2, 16'h000C, 32'd0);
        cmd(2'd2, 16'h0000, 32'd0);

        // Randomized command stream against the model
        for (int t = 0; t < 40; t++) begin
            r_op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: r_addr = 16'h0000;
                1: r_addr = 16'h0004;
                2: r_addr = 16'h0008;
                3: r_addr = 16'h000C;
                4: r_addr = 16'h0010;
                5: r_addr = 16'h0010;
                6: r_addr = 16'h0014;
                default: r_addr = 16'($urandom);
            endcase
            r_data = $urandom;
            if (r_addr == 16'h0000) r_data = 32'($urandom_range(0, 40));
            tdo_mode = int'($urandom_range(0, 2));
            cmd(r_op, r_addr, r_data);
        end
        cmd(2'd2, 16'h0000, 32'd0);
        cmd(2'd2, 16'h000C, 32'd0);

        chk("pulse_rule", pulse_viol, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
